cs_trgt_fringe_bridge: RTL

Parametrised target-side fringe bridge for split co-simulation, replacing the fixed three-channel target interface. It samples a mission clock in the `clk_i` utility domain and, on each mission edge, uploads the SUT output vector to the initiator. It then collects one downloaded payload per input channel and holds per-channel clock freezes until every channel has been refreshed. Transport is abstracted as two valid/ready streams, so the block is synthesizable and independent of the DPI layer that feeds it.

---
 rtl/cs_trgt_fringe_bridge.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cs_trgt_fringe_bridge.sv
// cs_trgt_fringe_bridge
//   Target-side fringe bridge for split co-simulation. On each rising edge of the
//   mission clock (sampled as data in the clk_i domain) it uploads the SUT output
//   vector over a valid/ready stream. It then collects one downloaded payload per
//   input channel, holding per-channel clock freezes until every channel has been
//   refreshed. Finally it applies all channels to the SUT at once.
//
//   Optional feature: define CS_TRGT_WATCHDOG_EN to build the WAIT_RX watchdog.
//   Without it, wd_err_o is tied low and the bridge waits for payloads indefinitely.
//
// Ports
//   clk_i, rst_i            utility clock, synchronous active-high reset
//   mclk_i                  mission clock, sampled as data
//   put_en_i, get_en_i      enable upload / download phases
//   up_valid_i, up_data_i   SUT output vector
//   tx_valid_o/ready_i/data_o   upload stream {up_valid, up_data}
//   rx_valid_i/ready_o/idx_i/data_i  download stream {wen, data} per channel
//   wen_o, data_o           applied per-channel write enable / data
//   freeze_clk_o            per-channel mission clock hold
//   wd_err_o, ovr_o         sticky watchdog timeout / overrun flags
module cs_trgt_fringe_bridge #(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned DW       = 8,
  parameter int unsigned WD_LIMIT = 10000
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mclk_i,
  input  logic                   put_en_i,
  input  logic                   get_en_i,
  input  logic                   up_valid_i,
  input  logic [DW-1:0]          up_data_i,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic [DW:0]            tx_data_o,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  input  logic [$clog2(N_CH):0]  rx_idx_i,
  input  logic [DW:0]            rx_data_i,
  output logic [N_CH-1:0]        wen_o,
  output logic [N_CH*DW-1:0]     data_o,
  output logic [N_CH-1:0]        freeze_clk_o,
  output logic                   wd_err_o,
  output logic                   ovr_o
);

  localparam int unsigned IdxW = $clog2(N_CH) + 1;

  typedef enum logic [1:0] {StIdle, StSend, StWaitRx, StApply} state_e;

  state_e              state_q, state_d;
  logic                mclk_q, mclk_prev_q, trig;
  logic                tx_valid_q, tx_valid_d;
  logic [DW:0]         tx_data_q, tx_data_d;
  logic                rx_ready_q, rx_ready_d;
  logic [N_CH-1:0]     got_q, got_d;
  logic [N_CH-1:0]     freeze_q, freeze_d;
  logic [N_CH-1:0]     wen_q, wen_d;
  logic [N_CH*DW-1:0]  data_q, data_d;
  logic                ovr_q, ovr_d;
  logic [DW:0]         shadow_q [N_CH];
  logic [DW:0]         shadow_d [N_CH];

`ifdef CS_TRGT_WATCHDOG_EN
  logic [31:0]         wd_cnt_q, wd_cnt_d;
  logic                wd_err_q, wd_err_d;
`endif

  // mclk_i is registered before edge detection, so the edge seen at clock k acts at k+1.
  assign trig = mclk_q & ~mclk_prev_q;

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    got_d      = got_q;
    freeze_d   = freeze_q;
    wen_d      = wen_q;
    data_d     = data_q;
    ovr_d      = ovr_q;
    shadow_d   = shadow_q;
`ifdef CS_TRGT_WATCHDOG_EN
    wd_cnt_d   = wd_cnt_q;
    wd_err_d   = wd_err_q;
`endif

    // Mission edges arriving while busy are flagged and dropped.
    if (trig && (state_q != StIdle)) ovr_d = 1'b1;

    case (state_q)
      StIdle: begin
        if (trig) begin
          if (put_en_i) begin
            tx_data_d = {up_valid_i, up_data_i};
            state_d   = StSend;
          end else if (get_en_i) begin
            state_d = StWaitRx;
          end
        end
      end
      StSend: begin
        if (tx_valid_q && tx_ready_i) state_d = get_en_i ? StWaitRx : StIdle;
      end
      StWaitRx: begin
        if (rx_valid_i && rx_ready_q) begin
          // Out-of-range indices match no channel and are silently dropped.
          for (int i = 0; i < int'(N_CH); i++) begin
            if (rx_idx_i == IdxW'(i)) begin
              shadow_d[i] = rx_data_i;
              got_d[i]    = 1'b1;
            end
          end
        end
        if (&got_q) begin
          // Freezes for the final channel are released together with APPLY.
          state_d = StApply;
        end else begin
          freeze_d = ~got_q;
`ifdef CS_TRGT_WATCHDOG_EN
          if (wd_cnt_q >= WD_LIMIT - 1) begin
            wd_err_d = 1'b1;
            got_d    = '0;
            state_d  = StIdle;
          end else begin
            wd_cnt_d = wd_cnt_q + 32'd1;
          end
`endif
        end
      end
      StApply: begin
        for (int i = 0; i < int'(N_CH); i++) begin
          wen_d[i]           = shadow_q[i][DW];
          data_d[i*DW +: DW] = shadow_q[i][DW-1:0];
        end
        got_d    = '0;
        freeze_d = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if ((state_d == StWaitRx) && (state_q != StWaitRx)) begin
      freeze_d = '1;
      got_d    = '0;
`ifdef CS_TRGT_WATCHDOG_EN
      wd_cnt_d = '0;
`endif
    end

    tx_valid_d = (state_d == StSend);
    rx_ready_d = (state_d == StWaitRx);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mclk_q      <= 1'b0;
      mclk_prev_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      rx_ready_q  <= 1'b0;
      got_q       <= '0;
      freeze_q    <= '0;
      wen_q       <= '0;
      data_q      <= '0;
      ovr_q       <= 1'b0;
      for (int i = 0; i < int'(N_CH); i++) shadow_q[i] <= '0;
`ifdef CS_TRGT_WATCHDOG_EN
      wd_cnt_q    <= '0;
      wd_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mclk_q      <= mclk_i;
      mclk_prev_q <= mclk_q;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      rx_ready_q  <= rx_ready_d;
      got_q       <= got_d;
      freeze_q    <= freeze_d;
      wen_q       <= wen_d;
      data_q      <= data_d;
      ovr_q       <= ovr_d;
      shadow_q    <= shadow_d;
`ifdef CS_TRGT_WATCHDOG_EN
      wd_cnt_q    <= wd_cnt_d;
      wd_err_q    <= wd_err_d;
`endif
    end
  end

`ifdef CS_TRGT_WATCHDOG_EN
  assign wd_err_o = wd_err_q;
`else
  logic unused_wd_limit;
  assign unused_wd_limit = (WD_LIMIT == 0);
  assign wd_err_o        = 1'b0;
`endif

  assign tx_valid_o   = tx_valid_q;
  assign tx_data_o    = tx_data_q;
  assign rx_ready_o   = rx_ready_q;
  assign wen_o        = wen_q;
  assign data_o       = data_q;
  assign freeze_clk_o = freeze_q;
  assign ovr_o        = ovr_q;

endmodule
